// File: rtl/des_sbox_pipe_if.sv
// des_sbox_pipe_if: stream bundle for the DES substitution stage.
//   din_valid/din_ready/din/din_tag     : input word handshake (din bit 0 = MSB)
//   dout_valid/dout_ready/dout/dout_tag : result handshake (dout bit 0 = MSB)
//   occupancy                           : count of valid pipeline stages
// slave is the view of the substitution unit; master is the view of the
// surrounding round datapath that feeds words in and takes results out.
interface des_sbox_pipe_if #(
  parameter int TAG_WIDTH = 4
);
  logic                 din_valid;
  logic                 din_ready;
  logic [0:47]          din;
  logic [TAG_WIDTH-1:0] din_tag;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [0:31]          dout;
  logic [TAG_WIDTH-1:0] dout_tag;
  logic [2:0]           occupancy;

  modport master (
    output din_valid, din, din_tag, dout_ready,
    input  din_ready, dout_valid, dout, dout_tag, occupancy
  );

  modport slave (
    input  din_valid, din, din_tag, dout_ready,
    output din_ready, dout_valid, dout, dout_tag, occupancy
  );
endinterface

// File: rtl/des_sbox_pipe.sv
// des_sbox_pipe: DES S1..S8 substitution (optionally followed by P) with a
// back-pressurable register pipeline and a sideband tag.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, empties every stage
//   bus     : des_sbox_pipe_if.slave
//             din[0:47]  six bits per box, bits 6i..6i+5 feed S(i+1)
//             dout[0:31] S-box nibbles (or their P permutation)
//             occupancy  number of stages currently holding a word
// Stage 1 captures the S-box result; later stages only delay it. P sits after
// the last register, so dout depends on registered state only.
module des_sbox_pipe #(
  parameter int PIPE_STAGES = 2,
  parameter bit APPLY_PERM  = 1'b1,
  parameter int TAG_WIDTH   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  des_sbox_pipe_if.slave bus
);

  // One 256-bit constant per box: entry e = row*16 + col, entry 0 is the most
  // significant nibble, so the table text reads like the published rows.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  // P: output bit j takes input bit PERM_SRC[j] (both 1-based from the MSB).
  localparam int PERM_SRC [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // ---------------------------------------------------------------- S-boxes
  logic [0:31] sbox_out;

  for (genvar gi = 0; gi < 8; gi++) begin : g_box
    logic [5:0] seg;
    logic [5:0] idx;
    assign seg = bus.din[6*gi +: 6];
    // Row is the outer bit pair, column the inner four bits.
    assign idx = {seg[5], seg[0], seg[4:1]};
    // Entry e occupies bits 4*(63-e)+3 .. 4*(63-e); 63-e is ~e for 6 bits.
    assign sbox_out[4*gi +: 4] = SBOX[gi][{~idx, 2'b00} +: 4];
  end

  // --------------------------------------------------------------- pipeline
  logic [PIPE_STAGES-1:0] vld_reg;
  logic [0:31]            data_reg [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]   tag_reg  [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] load;
  logic [PIPE_STAGES-1:0] in_vld;
  logic [0:31]            in_data [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]   in_tag  [PIPE_STAGES];
  logic [2:0]             occ;

  // Source of each stage: stage 0 takes the live lookup, the rest shift.
  always_comb begin
    in_vld     = '0;
    in_vld[0]  = bus.din_valid;
    in_data[0] = sbox_out;
    in_tag[0]  = bus.din_tag;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      in_vld[k]  = vld_reg[k-1];
      in_data[k] = data_reg[k-1];
      in_tag[k]  = tag_reg[k-1];
    end
  end

  // A stage may load when it is empty or its content leaves this edge. The
  // chain is evaluated from the output back so bubbles anywhere collapse.
  always_comb begin
    load = '0;
    load[PIPE_STAGES-1] = !vld_reg[PIPE_STAGES-1] || bus.dout_ready;
    for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
      load[k] = !vld_reg[k] || load[k+1];
    end
  end

  // Payload is only written for a valid incoming word: a drained stage keeps
  // its last value and junk on an idle din never reaches the registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_reg <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_reg[k] <= '0;
        tag_reg[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (load[k]) begin
          vld_reg[k] <= in_vld[k];
          if (in_vld[k]) begin
            data_reg[k] <= in_data[k];
            tag_reg[k]  <= in_tag[k];
          end
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      occ = occ + {2'b00, vld_reg[k]};
    end
  end

  // ----------------------------------------------------------------- output
  logic [0:31] last_data;
  logic [0:31] dout_w;

  assign last_data = data_reg[PIPE_STAGES-1];

  if (APPLY_PERM) begin : g_perm
    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
      assign dout_w[gi] = last_data[PERM_SRC[gi] - 1];
    end
  end else begin : g_raw
    assign dout_w = last_data;
  end

  assign bus.din_ready  = load[0];
  assign bus.dout_valid = vld_reg[PIPE_STAGES-1];
  assign bus.dout       = dout_w;
  assign bus.dout_tag   = tag_reg[PIPE_STAGES-1];
  assign bus.occupancy  = occ;

endmodule

// File: doc/des_sbox_pipe.md
Name: des_sbox_pipe

Overview:
- Full DES substitution stage: takes the 48-bit (expanded-right XOR round-key) word, applies S-boxes S1..S8 in parallel, and optionally applies the P permutation.
- Configurable register pipeline with valid/ready flow control and a sideband tag.
- Sits between the key-mixing XOR and the Feistel left-half XOR inside the DES round datapath.
- Replaces per-box instantiation with one parametrised, back-pressurable unit.

Parameters:
- PIPE_STAGES, 2, number of register stages input→output; legal 1..4.
- APPLY_PERM, 1, 1 = output is P(S1..S8), 0 = raw concatenated S-box output.
- TAG_WIDTH, 4, width of the sideband tag carried alongside data; legal ≥1.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- din_valid  in  1  input word valid
- din_ready  out  1  unit can accept input this cycle
- din  in  [0:47]  bit 0 = MSB; bits 6i..6i+5 feed S(i+1)
- din_tag  in  TAG_WIDTH  opaque tag, returned with result
- dout_valid  out  1  result valid
- dout_ready  in  1  downstream accepts result
- dout  out  [0:31]  bits 4i..4i+3 = S(i+1) output (before P)
- dout_tag  out  TAG_WIDTH  tag of the result
- occupancy  out  3  number of valid stages currently held, 0..PIPE_STAGES

Behaviour:
- One clock domain. reset_n is asynchronous and active-low; it clears every stage valid bit immediately.
- Reset values:
  - dout_valid=0, dout=0, dout_tag=0, occupancy=0.
  - din_ready=1 once reset_n is high.
- S-box addressing, per box: row = {b0,b5}, column = b1..b4; standard FIPS 46-3 tables S1..S8.
- The S-box lookup is combinational on din and captured in stage 1. Stages 2..PIPE_STAGES are pure data/tag/valid delay.
- P permutation (when APPLY_PERM=1) is applied combinationally between the last-stage register and dout. dout is therefore a function of registered state only, with no combinational path from din.
- Accepted transfer: din_valid&&din_ready on a rising edge. Emitted transfer: dout_valid&&dout_ready.
- Latency: a word accepted at edge N is visible on dout at N+PIPE_STAGES-1 after the edge (dout_valid high from edge N+PIPE_STAGES-1 when unstalled). Concretely, PIPE_STAGES=1 gives dout valid the cycle after acceptance.
- Per-stage advance rule: stage k loads from stage k-1 when stage k is empty, or when stage k is about to hand off (next stage advancing, or dout_ready for the last stage). Bubbles collapse: an empty stage always accepts.
- din_ready = (stage1 empty) OR (stage1 advancing). Full throughput of one word per cycle with dout_ready held high.
- Stalled stages hold data and tag unchanged. dout and dout_tag must stay stable while dout_valid=1 and dout_ready=0.
- Data is never dropped or duplicated; output order equals input order.
- Simultaneous events:
  - Accept and emit in the same cycle while full keeps occupancy constant.
  - occupancy = popcount of stage valid bits, updated each edge.
- Full: all stages valid and dout_ready=0 → din_ready=0; input is ignored even if din_valid=1.
- Empty: dout_valid=0; dout holds its last value (no reset-to-zero on drain).
- Reset mid-operation: all in-flight words are discarded, outputs return to reset values asynchronously, and no partial result is emitted after release.
- X-safety: din content is don't-care when din_valid=0, and must not propagate into dout_valid.

Test Plan:
- Zero vector, PIPE_STAGES=2, APPLY_PERM=0: din=48'h0, tag=3 → dout=32'hEFA72C4D, dout_tag=3, dout_valid high 1 cycle after acceptance.
- Worked DES round vector, APPLY_PERM=0: din=48'h6117BA866527 → dout=32'h5C82B597. Same input with APPLY_PERM=1 → dout=32'h234AA9BB.
- Throughput: 16 back-to-back words with random data/tags, dout_ready=1 → 16 results in order, one per cycle, din_ready never low, matching a scoreboard model.
- Backpressure, PIPE_STAGES=4: hold dout_ready=0 while streaming.
  - din_ready drops after 4 accepts; occupancy=4; dout stable.
  - Release dout_ready → all 4 words drain in order.
  - Random ready toggling must show no loss or duplication.
- Reset mid-stream: assert reset_n low asynchronously between edges with occupancy=3 → dout_valid=0 and occupancy=0 immediately. The first output after release is the first word accepted post-reset.
- Exhaustive per-box check: sweep each 6-bit segment 0..63 with other segments zero → each S-box nibble matches its FIPS table entry, for every PIPE_STAGES value 1..4.
